pc_fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly downstream of the branch/jump resolution unit. It holds the program counter and advances it by 4, or redirects to the resolved target when that unit asserts its select. It issues one instruction-memory request at a time over a req/gnt/rvalid handshake. It delivers {PC, instruction, valid} into the IF/ID pipeline register, honouring stall from the hazard unit and flushing wrong-path fetches on redirect.

---
 rtl/pc_fetch_stage_if.sv | 27 ++
 rtl/pc_fetch_stage.sv | 151 +++++++++++++++
 tb/tb_pc_fetch_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
// One request outstanding at a time: req/gnt handshake, then a single rvalid beat.
interface pc_fetch_stage_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem fetch FSM,
// skid buffer for stalled responses and the IF/ID pipeline register.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stall_i,
    input  logic                pcmux_sel_i,
    input  logic [31:0]         pc_taken_i,
    pc_fetch_stage_if.master    imem,
    output logic [31:0]         D_Pc_o,
    output logic [31:0]         D_Pc4_o,
    output logic [31:0]         D_Instr_o,
    output logic                D_valid_o
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          r_state,      w_state_nxt;
    logic [XLEN-1:0] r_pc,         w_pc_nxt;
    logic [XLEN-1:0] r_fetch_pc,   w_fetch_pc_nxt;
    logic            r_kill,       w_kill_nxt;
    logic [XLEN-1:0] r_skid_pc,    w_skid_pc_nxt;
    logic [XLEN-1:0] r_skid_instr, w_skid_instr_nxt;
    logic [XLEN-1:0] r_d_pc,       w_d_pc_nxt;
    logic [XLEN-1:0] r_d_pc4,      w_d_pc4_nxt;
    logic [XLEN-1:0] r_d_instr,    w_d_instr_nxt;
    logic            r_d_valid,    w_d_valid_nxt;
    logic [XLEN-1:0] w_target;

    assign w_target = pc_taken_i & ~XLEN'(3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_fetch_pc   <= '0;
            r_kill       <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_d_pc       <= '0;
            r_d_pc4      <= XLEN'(4);
            r_d_instr    <= NOP_INSTR;
            r_d_valid    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_kill       <= w_kill_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_d_pc       <= w_d_pc_nxt;
            r_d_pc4      <= w_d_pc4_nxt;
            r_d_instr    <= w_d_instr_nxt;
            r_d_valid    <= w_d_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_fetch_pc_nxt   = r_fetch_pc;
        w_kill_nxt       = r_kill;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_instr_nxt = r_skid_instr;
        w_d_pc_nxt       = r_d_pc;
        w_d_pc4_nxt      = r_d_pc4;
        // Without a load, IF/ID holds under stall and otherwise becomes a bubble.
        w_d_instr_nxt    = stall_i ? r_d_instr : NOP_INSTR;
        w_d_valid_nxt    = stall_i ? r_d_valid : 1'b0;

        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (imem.imem_gnt_i) begin
                    w_fetch_pc_nxt = r_pc;
                    w_pc_nxt       = r_pc + XLEN'(4);
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid_i) begin
                    if (r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else if (!stall_i) begin
                        w_d_pc_nxt    = r_fetch_pc;
                        w_d_pc4_nxt   = r_fetch_pc + XLEN'(4);
                        w_d_instr_nxt = imem.imem_rdata_i;
                        w_d_valid_nxt = 1'b1;
                        w_state_nxt   = S_REQ;
                    end else begin
                        w_skid_pc_nxt    = r_fetch_pc;
                        w_skid_instr_nxt = imem.imem_rdata_i;
                        w_state_nxt      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    w_d_pc_nxt    = r_skid_pc;
                    w_d_pc4_nxt   = r_skid_pc + XLEN'(4);
                    w_d_instr_nxt = r_skid_instr;
                    w_d_valid_nxt = 1'b1;
                    w_state_nxt   = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Redirect overrides everything above, stall included.
        if (pcmux_sel_i) begin
            w_pc_nxt         = w_target;
            w_d_instr_nxt    = NOP_INSTR;
            w_d_valid_nxt    = 1'b0;
            w_skid_pc_nxt    = '0;
            w_skid_instr_nxt = '0;
            case (r_state)
                S_REQ: begin
                    if (imem.imem_gnt_i) w_kill_nxt = 1'b1;
                end
                S_WAIT: begin
                    if (imem.imem_rvalid_i) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_kill_nxt  = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    assign imem.imem_req_o  = (r_state == S_REQ);
    assign imem.imem_addr_o = r_pc;

    assign D_Pc_o    = r_d_pc;
    assign D_Pc4_o   = r_d_pc4;
    assign D_Instr_o = r_d_instr;
    assign D_valid_o = r_d_valid;
endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage: streaming fetch, stall/skid,
// redirect flushes, PC wrap and reset during an outstanding fetch.
module tb_pc_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        pcmux_sel_i;
    logic [31:0] pc_taken_i;
    logic [31:0] D_Pc_o;
    logic [31:0] D_Pc4_o;
    logic [31:0] D_Instr_o;
    logic        D_valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_stage_if u_if ();

    pc_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .stall_i     (stall_i),
        .pcmux_sel_i (pcmux_sel_i),
        .pc_taken_i  (pc_taken_i),
        .imem        (u_if),
        .D_Pc_o      (D_Pc_o),
        .D_Pc4_o     (D_Pc4_o),
        .D_Instr_o   (D_Instr_o),
        .D_valid_o   (D_valid_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_dreg(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic valid);
        chk({tag, "_pc"},    D_Pc_o,    pc);
        chk({tag, "_pc4"},   D_Pc4_o,   pc + 32'd4);
        chk({tag, "_instr"}, D_Instr_o, instr);
        chk({tag, "_valid"}, 32'(D_valid_o), 32'(valid));
    endtask

    initial begin
        rst_ni            = 1'b0;
        stall_i           = 1'b0;
        pcmux_sel_i       = 1'b0;
        pc_taken_i        = '0;
        u_if.imem_gnt_i    = 1'b0;
        u_if.imem_rvalid_i = 1'b0;
        u_if.imem_rdata_i  = '0;

        // Reset values
        tick();
        tick();
        chk("rst_req",  32'(u_if.imem_req_o), 32'd0);
        chk("rst_addr", u_if.imem_addr_o, 32'h0);
        chk("rst_dpc",  D_Pc_o, 32'h0);
        chk("rst_dpc4", D_Pc4_o, 32'h4);
        chk("rst_instr", D_Instr_o, NOP);
        chk("rst_valid", 32'(D_valid_o), 32'd0);

        // Streaming fetch: gnt always high, response one cycle after grant
        rst_ni          = 1'b1;
        u_if.imem_gnt_i = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("strm_req",  32'(u_if.imem_req_o), 32'd1);
            chk("strm_addr", u_if.imem_addr_o, 32'(4 * k));
            tick();
            chk("strm_bubble", 32'(D_valid_o), 32'd0);
            chk("strm_wait_req", 32'(u_if.imem_req_o), 32'd0);
            u_if.imem_rvalid_i = 1'b1;
            u_if.imem_rdata_i  = 32'(4 * k) ^ TAG;
            tick();
            chk_dreg("strm", 32'(4 * k), 32'(4 * k) ^ TAG, 1'b1);
            u_if.imem_rvalid_i = 1'b0;
        end

        // Response under a 3-cycle stall goes to the skid buffer
        stall_i = 1'b1;
        tick();
        chk_dreg("stl_hold0", 32'd12, 32'd12 ^ TAG, 1'b1);
        u_if.imem_gnt_i    = 1'b0;
        u_if.imem_rvalid_i = 1'b1;
        u_if.imem_rdata_i  = 32'd16 ^ TAG;
        tick();
        u_if.imem_rvalid_i = 1'b0;
        chk_dreg("stl_hold1", 32'd12, 32'd12 ^ TAG, 1'b1);
        chk("stl_req1", 32'(u_if.imem_req_o), 32'd0);
        tick();
        chk("stl_req2", 32'(u_if.imem_req_o), 32'd0);
        chk_dreg("stl_hold2", 32'd12, 32'd12 ^ TAG, 1'b1);
        stall_i = 1'b0;
        tick();
        chk_dreg("stl_release", 32'd16, 32'd16 ^ TAG, 1'b1);
        chk("stl_next_addr", u_if.imem_addr_o, 32'd20);

        // Redirect while waiting; the late response must be dropped
        u_if.imem_gnt_i = 1'b1;
        tick();
        u_if.imem_gnt_i = 1'b0;
        pcmux_sel_i     = 1'b1;
        pc_taken_i      = 32'h0000_0103;
        tick();
        pcmux_sel_i = 1'b0;
        chk("rdw_addr",  u_if.imem_addr_o, 32'h100);
        chk("rdw_valid", 32'(D_valid_o), 32'd0);
        tick();
        u_if.imem_rvalid_i = 1'b1;
        u_if.imem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        u_if.imem_rvalid_i = 1'b0;
        chk("rdw_drop_valid", 32'(D_valid_o), 32'd0);
        chk("rdw_drop_instr", D_Instr_o, NOP);
        chk("rdw_req", 32'(u_if.imem_req_o), 32'd1);
        chk("rdw_req_addr", u_if.imem_addr_o, 32'h100);
        u_if.imem_gnt_i = 1'b1;
        tick();
        u_if.imem_gnt_i    = 1'b0;
        u_if.imem_rvalid_i = 1'b1;
        u_if.imem_rdata_i  = 32'h100 ^ TAG;
        tick();
        u_if.imem_rvalid_i = 1'b0;
        chk_dreg("rdw_target", 32'h100, 32'h100 ^ TAG, 1'b1);

        // Redirect coinciding with grant and stall: flush wins, request killed
        u_if.imem_gnt_i = 1'b1;
        stall_i         = 1'b1;
        pcmux_sel_i     = 1'b1;
        pc_taken_i      = 32'h0000_0200;
        tick();
        pcmux_sel_i     = 1'b0;
        u_if.imem_gnt_i = 1'b0;
        chk_dreg("rgs_flush", 32'h100, NOP, 1'b0);
        chk("rgs_addr", u_if.imem_addr_o, 32'h200);
        u_if.imem_rvalid_i = 1'b1;
        u_if.imem_rdata_i  = 32'hBAD0_0104;
        tick();
        u_if.imem_rvalid_i = 1'b0;
        chk("rgs_kill_req", 32'(u_if.imem_req_o), 32'd1);
        chk("rgs_kill_valid", 32'(D_valid_o), 32'd0);
        chk("rgs_kill_addr", u_if.imem_addr_o, 32'h200);
        stall_i         = 1'b0;
        u_if.imem_gnt_i = 1'b1;
        tick();
        u_if.imem_gnt_i    = 1'b0;
        u_if.imem_rvalid_i = 1'b1;
        u_if.imem_rdata_i  = 32'h200 ^ TAG;
        tick();
        u_if.imem_rvalid_i = 1'b0;
        chk_dreg("rgs_target", 32'h200, 32'h200 ^ TAG, 1'b1);

        // PC wrap from the top word; misaligned target bits cleared
        pcmux_sel_i = 1'b1;
        pc_taken_i  = 32'hFFFF_FFFF;
        tick();
        pcmux_sel_i = 1'b0;
        chk("wrap_addr_top", u_if.imem_addr_o, 32'hFFFF_FFFC);
        chk("wrap_req", 32'(u_if.imem_req_o), 32'd1);
        u_if.imem_gnt_i = 1'b1;
        tick();
        u_if.imem_gnt_i = 1'b0;
        chk("wrap_addr_zero", u_if.imem_addr_o, 32'h0);
        u_if.imem_rvalid_i = 1'b1;
        u_if.imem_rdata_i  = 32'h5A5A_5A5A;
        tick();
        u_if.imem_rvalid_i = 1'b0;
        chk_dreg("wrap_d", 32'hFFFF_FFFC, 32'h5A5A_5A5A, 1'b1);

        // Reset during WAIT; response after release is ignored
        u_if.imem_gnt_i = 1'b1;
        tick();
        u_if.imem_gnt_i = 1'b0;
        chk("rstw_addr_pre", u_if.imem_addr_o, 32'h4);
        rst_ni = 1'b0;
        #2;
        chk_dreg("rstw_async", 32'h0, NOP, 1'b0);
        chk("rstw_req", 32'(u_if.imem_req_o), 32'd0);
        chk("rstw_addr", u_if.imem_addr_o, 32'h0);
        tick();
        rst_ni             = 1'b1;
        u_if.imem_rvalid_i = 1'b1;
        u_if.imem_rdata_i  = 32'hBAD0_0000;
        tick();
        u_if.imem_rvalid_i = 1'b0;
        chk_dreg("rstw_ignored", 32'h0, NOP, 1'b0);
        chk("rstw_first_req", 32'(u_if.imem_req_o), 32'd1);
        chk("rstw_first_addr", u_if.imem_addr_o, 32'h0);
        tick();
        chk_dreg("rstw_still_idle", 32'h0, NOP, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
